frame_buffer_flipper: RTL and testbench

- Next-generation page flipper for the Cave video pipeline; manages the frame-buffer pages in DDR shared by the sprite frame writer and the video frame reader.
- Supports double buffering (2 pages) and triple buffering (3 pages), selected at reset.
- Flips only at reader sync points, so the display never tears.
- Reports writer stall and dropped frames.

---
 rtl/cave_video_pkg.sv | 13 +
 rtl/sat_counter.sv | 23 ++
 rtl/frame_buffer_flipper.sv | 107 ++++++++++
 tb/tb_frame_buffer_flipper.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cave_video_pkg.sv
// rtl/cave_video_pkg.sv - shared frame-buffer page types and defaults for the Cave video pipeline
package cave_video_pkg;

  typedef logic [1:0] page_index_t;

  localparam page_index_t RESET_RD_PAGE    = 2'd0;
  localparam page_index_t RESET_WR_PAGE    = 2'd1;
  localparam page_index_t RESET_SPARE_PAGE = 2'd2;

  localparam logic [31:0] FB_BASE_ADDR  = 32'h2420_0000;
  localparam int          FB_PAGE_SHIFT = 19;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/frame_buffer_flipper.sv
// rtl/frame_buffer_flipper.sv - double/triple frame-buffer page flipper; flips only at reader sync
module frame_buffer_flipper
  import cave_video_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(FB_BASE_ADDR),
  parameter int                    PAGE_SHIFT  = FB_PAGE_SHIFT,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   triple_mode,
  input  logic                   write_done,
  input  logic                   read_sync,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [1:0]             rd_index,
  output logic [1:0]             wr_index,
  output logic                   pending,
  output logic                   write_stall,
  output logic                   dropped,
  output logic [COUNT_WIDTH-1:0] dropped_count
);

  page_index_t r_rd, r_wr, r_spare;
  logic        r_pend, r_mode, r_dropped;

  page_index_t w_rd_nxt, w_wr_nxt, w_spare_nxt;
  logic        w_pend_nxt, w_drop;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd      <= RESET_RD_PAGE;
      r_wr      <= RESET_WR_PAGE;
      r_spare   <= RESET_SPARE_PAGE;
      r_pend    <= 1'b0;
      r_mode    <= triple_mode;
      r_dropped <= 1'b0;
    end else begin
      r_rd      <= w_rd_nxt;
      r_wr      <= w_wr_nxt;
      r_spare   <= w_spare_nxt;
      r_pend    <= w_pend_nxt;
      r_dropped <= w_drop;
    end
  end

  always_comb begin
    w_rd_nxt    = r_rd;
    w_wr_nxt    = r_wr;
    w_spare_nxt = r_spare;
    w_pend_nxt  = r_pend;
    w_drop      = 1'b0;
    if (r_mode) begin
      // In triple mode the pending flag always describes the spare page.
      if (write_done && read_sync) begin
        w_rd_nxt    = r_wr;
        w_wr_nxt    = r_spare;
        w_spare_nxt = r_rd;
        w_pend_nxt  = 1'b0;
        w_drop      = r_pend;
      end else if (write_done) begin
        w_wr_nxt    = r_spare;
        w_spare_nxt = r_wr;
        w_pend_nxt  = 1'b1;
        w_drop      = r_pend;
      end else if (read_sync && r_pend) begin
        w_rd_nxt    = r_spare;
        w_spare_nxt = r_rd;
        w_pend_nxt  = 1'b0;
      end
    end else begin
      if (write_done && read_sync) begin
        w_rd_nxt   = r_wr;
        w_wr_nxt   = r_rd;
        w_pend_nxt = 1'b0;
        w_drop     = r_pend;
      end else if (write_done) begin
        w_pend_nxt = 1'b1;
        w_drop     = r_pend;
      end else if (read_sync && r_pend) begin
        w_rd_nxt   = r_wr;
        w_wr_nxt   = r_rd;
        w_pend_nxt = 1'b0;
      end
    end
  end

  // Counter is fed the same condition as the dropped register so both move together.
  sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_drop_counter (
    .clock (clock),
    .reset (reset),
    .inc   (w_drop),
    .count (dropped_count)
  );

  assign rd_addr     = BASE_ADDR + (ADDR_WIDTH'(r_rd) << PAGE_SHIFT);
  assign wr_addr     = BASE_ADDR + (ADDR_WIDTH'(r_wr) << PAGE_SHIFT);
  assign rd_index    = r_rd;
  assign wr_index    = r_wr;
  assign pending     = r_pend;
  assign write_stall = r_pend & ~r_mode;
  assign dropped     = r_dropped;

endmodule

// File: tb/tb_frame_buffer_flipper.sv
// tb/tb_frame_buffer_flipper.sv - scoreboard bench for frame_buffer_flipper with directed vectors
module tb_frame_buffer_flipper;

  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          triple_mode = 1'b1;
  logic          write_done = 1'b0;
  logic          read_sync = 1'b0;
  logic [31:0]   rd_addr, wr_addr;
  logic [1:0]    rd_index, wr_index;
  logic          pending, write_stall, dropped;
  logic [CW-1:0] dropped_count;

  frame_buffer_flipper #(
    .COUNT_WIDTH (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .triple_mode   (triple_mode),
    .write_done    (write_done),
    .read_sync     (read_sync),
    .rd_addr       (rd_addr),
    .wr_addr       (wr_addr),
    .rd_index      (rd_index),
    .wr_index      (wr_index),
    .pending       (pending),
    .write_stall   (write_stall),
    .dropped       (dropped),
    .dropped_count (dropped_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    int          vec;
    logic [1:0]  r;
    logic [1:0]  w;
    logic        pend;
    logic        stall;
    logic        drop;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vec_no = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] page_addr(input logic [1:0] idx);
    return 32'h2420_0000 + (32'(idx) << 19);
  endfunction

  task automatic chk(input string name, input int vec, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, vec, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("rd_index", e.vec, 32'(rd_index), 32'(e.r));
      chk("wr_index", e.vec, 32'(wr_index), 32'(e.w));
      chk("rd_addr", e.vec, rd_addr, page_addr(e.r));
      chk("wr_addr", e.vec, wr_addr, page_addr(e.w));
      chk("pending", e.vec, 32'(pending), 32'(e.pend));
      chk("write_stall", e.vec, 32'(write_stall), 32'(e.stall));
      chk("dropped", e.vec, 32'(dropped), 32'(e.drop));
      chk("dropped_count", e.vec, 32'(dropped_count), 32'(e.cnt));
    end
  end

  // One clock of stimulus plus the outputs expected right after that edge.
  task automatic step(input logic rst, input logic tm, input logic wd, input logic rs,
                      input logic [1:0] er, input logic [1:0] ew, input logic ep,
                      input logic es, input logic ed, input logic [CW-1:0] ec);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst;
    triple_mode = tm;
    write_done = wd;
    read_sync = rs;
    vec_no++;
    e.due = cyc + 1;
    e.vec = vec_no;
    e.r = er; e.w = ew; e.pend = ep; e.stall = es; e.drop = ed; e.cnt = ec;
    q.push_back(e);
  endtask

  initial begin
    // Triple mode reset and idle hold
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    // write_done, then read_sync five cycles later
    step(0, 1, 1, 0, 0, 2, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 2, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 2, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 2, 0, 0, 0, 0);
    // Two write_done pulses without read_sync
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 2, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, 1, 0, 1, 1);
    step(0, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    step(0, 1, 0, 1, 2, 1, 0, 0, 0, 1);
    // Simultaneous write_done and read_sync from reset, then with a pending frame
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 2, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 2, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 2, 0, 0, 1, 1);
    step(0, 1, 0, 1, 0, 2, 0, 0, 0, 1);
    // Double mode
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 1, 0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1, 0, 1, 1, 0, 1);
    step(0, 0, 1, 1, 0, 1, 0, 0, 1, 2);
    step(0, 0, 1, 1, 1, 0, 0, 0, 0, 2);
    // triple_mode raised outside reset is ignored
    step(0, 1, 1, 0, 1, 0, 1, 1, 0, 2);
    // Saturation of the 2-bit counter
    step(0, 1, 1, 0, 1, 0, 1, 1, 1, 3);
    step(0, 1, 1, 0, 1, 0, 1, 1, 1, 3);
    step(0, 1, 1, 0, 1, 0, 1, 1, 1, 3);
    // Reset with a frame pending clears everything
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);

    @(posedge clock);
    #1;
    write_done = 0;
    read_sync = 0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
